// File: rtl/display_pkg.sv
// Shared definitions for the memory-mapped 7-segment scanner: register map,
// CTRL field layout and the hex-to-segment table.
package display_pkg;

    localparam logic [1:0] OFF_DIGITS = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_RAW    = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_MODE_BIT  = 1;
    localparam int CTRL_DP_LSB    = 8;
    localparam int CTRL_BLANK_LSB = 16;

    localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

    // Segment a is bit 0, g is bit 6; all patterns are active-high.
    function automatic logic [6:0] hex7(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg_hex_decoder
    import display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = hex7(value);

endmodule

// File: rtl/mmio_seg_scanner.sv
// Memory-mapped multi-digit 7-segment controller: register file, scan
// counters, hex/raw output select and registered, polarity-adjusted pins.
module mmio_seg_scanner
    import display_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h4000_0010,
    parameter int          NUM_DIGITS       = 4,
    parameter int          SCAN_DIV         = 50000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             MemBus_Address,
    input  logic [31:0]             MemBus_Write_Data,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    output logic [31:0]             Device_Read_Data,
    output logic                    Device_Hit,
    output logic [NUM_DIGITS+7:0]   BCD_control
);

    localparam int OUT_W = NUM_DIGITS + 8;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]            IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_POL = ANODE_ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]            SEG_POL   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [OUT_W-1:0]      POL_MASK  = {ANODE_POL, SEG_POL};

    logic                      hit;
    logic [1:0]                offset;
    logic                      wr_en;
    logic                      ctrl_wr;
    logic                      scan_run;

    logic [4*NUM_DIGITS-1:0]   digits_reg;
    logic                      en_reg;
    logic                      mode_reg;
    logic [NUM_DIGITS-1:0]     dp_reg;
    logic [NUM_DIGITS-1:0]     blank_reg;
    logic [OUT_W-1:0]          raw_reg;
    logic [DIV_W-1:0]          div_reg,   div_next;
    logic [2:0]                idx_reg,   idx_next;
    logic [15:0]               frame_reg, frame_next;
    logic [OUT_W-1:0]          pins_reg;

    logic [31:0]               digits_word;
    logic [31:0]               ctrl_word;
    logic [31:0]               read_word;
    logic [7:0]                dp_word;
    logic [7:0]                blank_word;
    logic [3:0]                cur_nibble;
    logic [6:0]                cur_seg;
    logic [NUM_DIGITS-1:0]     anode_vec;
    logic [OUT_W-1:0]          logical_out;
    logic                      unused_bits;

    assign hit      = (MemBus_Address[31:4] == BASE_ADDR[31:4]);
    assign offset   = MemBus_Address[3:2];
    assign wr_en    = MemWrite && hit;
    assign ctrl_wr  = wr_en && (offset == OFF_CTRL);
    assign scan_run = en_reg && !mode_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_reg <= '0;
            en_reg     <= CTRL_RESET[CTRL_EN_BIT];
            mode_reg   <= CTRL_RESET[CTRL_MODE_BIT];
            dp_reg     <= '0;
            blank_reg  <= '0;
            raw_reg    <= '0;
        end else if (wr_en) begin
            case (offset)
                OFF_DIGITS: digits_reg <= MemBus_Write_Data[4*NUM_DIGITS-1:0];
                OFF_CTRL: begin
                    en_reg    <= MemBus_Write_Data[CTRL_EN_BIT];
                    mode_reg  <= MemBus_Write_Data[CTRL_MODE_BIT];
                    dp_reg    <= MemBus_Write_Data[CTRL_DP_LSB +: NUM_DIGITS];
                    blank_reg <= MemBus_Write_Data[CTRL_BLANK_LSB +: NUM_DIGITS];
                end
                OFF_RAW:    raw_reg <= MemBus_Write_Data[OUT_W-1:0];
                default:    ;
            endcase
        end
    end

    // A CTRL write restarts the scan even if the counters would advance.
    always_comb begin
        div_next   = div_reg;
        idx_next   = idx_reg;
        frame_next = frame_reg;
        if (ctrl_wr) begin
            div_next   = '0;
            idx_next   = '0;
            frame_next = '0;
        end else if (scan_run) begin
            if (div_reg == DIV_LAST) begin
                div_next = '0;
                if (idx_reg == IDX_LAST) begin
                    idx_next   = '0;
                    frame_next = frame_reg + 16'd1;
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end else begin
                div_next = div_reg + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg   <= '0;
            idx_reg   <= '0;
            frame_reg <= '0;
        end else begin
            div_reg   <= div_next;
            idx_reg   <= idx_next;
            frame_reg <= frame_next;
        end
    end

    // Widen to 8 digits so the 3-bit index selects without width games.
    assign digits_word = 32'(digits_reg);
    assign dp_word     = 8'(dp_reg);
    assign blank_word  = 8'(blank_reg);
    assign cur_nibble  = digits_word[{idx_reg, 2'b00} +: 4];

    seg_hex_decoder u_hex_decoder (
        .value (cur_nibble),
        .seg   (cur_seg)
    );

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign anode_vec[gi] = (idx_reg == 3'(gi));
        end
    endgenerate

    always_comb begin
        logical_out = '0;
        if (en_reg) begin
            if (mode_reg) begin
                logical_out = raw_reg;
            end else if (!blank_word[idx_reg]) begin
                logical_out = {anode_vec, dp_word[idx_reg], cur_seg};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pins_reg <= POL_MASK;
        end else begin
            pins_reg <= logical_out ^ POL_MASK;
        end
    end

    always_comb begin
        ctrl_word                                 = '0;
        ctrl_word[CTRL_EN_BIT]                    = en_reg;
        ctrl_word[CTRL_MODE_BIT]                  = mode_reg;
        ctrl_word[CTRL_DP_LSB +: NUM_DIGITS]      = dp_reg;
        ctrl_word[CTRL_BLANK_LSB +: NUM_DIGITS]   = blank_reg;
    end

    always_comb begin
        case (offset)
            OFF_DIGITS: read_word = digits_word;
            OFF_CTRL:   read_word = ctrl_word;
            OFF_RAW:    read_word = 32'(raw_reg);
            default:    read_word = {frame_reg, 13'd0, idx_reg};
        endcase
    end

    assign Device_Read_Data = (MemRead && hit) ? read_word : 32'h0;
    assign Device_Hit       = hit;
    assign BCD_control      = pins_reg;

    // Byte lanes and write-data bits beyond the configured width are don't-care.
    assign unused_bits = &{1'b0, MemBus_Address[1:0], MemBus_Write_Data};

endmodule

// File: doc/mmio_seg_scanner.md
Name: mmio_seg_scanner

Overview:
- Parametrised memory-mapped 7-segment display controller; next generation of the fixed 4-digit BCD display peripheral on the CPU data bus.
- Sits beside the CPU on MemBus_* signals in the board top and drives the multiplexed display pins.
- Adds configurable digit count, hardware hex decode with time-multiplexed scanning, raw legacy mode, decimal-point and blank masks, pin polarity options, a scan status/frame counter, and bus read-back.

Parameters:
- BASE_ADDR, 32'h4000_0010, word-aligned base of the 16-byte register window.
- NUM_DIGITS, 4, digits driven; legal 1..8.
- SCAN_DIV, 50000, clk cycles each digit is lit; legal >= 2.
- ANODE_ACTIVE_LOW, 1, invert the anode field at the pins.
- SEG_ACTIVE_LOW, 1, invert the segment field at the pins.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- MemBus_Address  input  32  byte address from the CPU.
- MemBus_Write_Data  input  32  write data.
- MemRead  input  1  read strobe.
- MemWrite  input  1  write strobe, sampled at the rising edge of clk.
- Device_Read_Data  output  32  read data; 0 when not selected.
- Device_Hit  output  1  high when the address is inside the window.
- BCD_control  output  NUM_DIGITS+8  pin drive, {anodes[NUM_DIGITS-1:0], dp, g, f, e, d, c, b, a}.

Behaviour:
- Decode: hit = (MemBus_Address[31:4] == BASE_ADDR[31:4]). Offset is Address[3:2]. Address[1:0] is ignored.
- Register 0x0 DIGITS, RW: nibble i (bits 4i+3:4i) is the hex value of digit i. Bits above 4*NUM_DIGITS read 0. Reset value 0.
- Register 0x4 CTRL, RW:
  - [0] EN, reset value 1.
  - [1] MODE: 0 = hex scan, 1 = raw. Reset value 0.
  - [15:8] DP mask.
  - [23:16] BLANK mask.
  - Unused bits and mask bits at or above NUM_DIGITS read 0.
- Register 0x8 RAW, RW: bits [NUM_DIGITS+7:0] hold the logical pin pattern. Reset value 0.
- Register 0xC STATUS, RO; writes are ignored:
  - [2:0] current scan index.
  - [31:16] frame count, +1 each time the index wraps from NUM_DIGITS-1 to 0, wraps modulo 2^16.
- Writes: on a clk edge with MemWrite && hit, the register is updated at that edge.
- Reads: Device_Read_Data is combinational; equals the register value when MemRead && hit, otherwise 32'h0. A read concurrent with a write returns the pre-write value.
- Scan counters:
  - div counts 0..SCAN_DIV-1.
  - idx advances when div == SCAN_DIV-1 and wraps at NUM_DIGITS-1.
  - Counters run only when EN=1 and MODE=0; otherwise they hold.
- Any write to CTRL clears div, idx and frame count at that edge. That write has priority over a same-edge advance.
- Logical output, hex mode with EN=1:
  - anodes = one-hot(idx).
  - seg[6:0] = hex7(DIGITS nibble idx).
  - seg[7] = DP[idx].
  - If BLANK[idx] is set, anodes and seg are all 0.
- hex7 table (a = bit0): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Logical output, raw mode with EN=1: equals RAW[NUM_DIGITS+7:0].
- EN=0: logical output is all 0, i.e. display dark.
- Pins: logical output XOR polarity masks, then registered. BCD_control therefore lags the registers and counters by exactly 1 cycle.
- Reset assertion (async, any time, including mid-frame or mid-write):
  - All registers, counters and the output flop go to their reset values immediately.
  - BCD_control goes to the inactive pattern: all anodes off, all segments off after polarity.
- Release of reset is synchronous to the next clk edge.

Decomposition:
- Shared package display_pkg holds:
  - register offsets (OFF_DIGITS=0, OFF_CTRL=1, OFF_RAW=2, OFF_STATUS=3);
  - CTRL field positions;
  - the CTRL reset constant 32'h0000_0001;
  - the hex7 function.
- One sub-module, seg_hex_decoder: combinational 4-bit value to 7-bit pattern. The scan logic and register file stay in mmio_seg_scanner.

Test Plan:
- Reset: hold reset=0 with mid-frame stimulus -> with defaults (NUM_DIGITS=4, active-low), BCD_control = 12'hFFF. CTRL reads 32'h1; DIGITS and STATUS read 0.
- Hex scan (SCAN_DIV=4): write DIGITS=32'h0000_1A3F -> BCD_control logical pattern, in index order each held 4 cycles:
  - {0001, 71}, {0010, 4F}, {0100, 77}, {1000, 06};
  - STATUS[31:16] increments after every 16 cycles.
- Masks: write CTRL=32'h0002_0101 -> digit 0 shows seg[7]=1; digit 1 slot is fully dark; counters restart at idx=0.
- Raw mode: write RAW=32'h0000_0A5C, then CTRL=32'h3 -> logical output 12'hA5C one cycle after the CTRL write; STATUS index is frozen.
- Bus edge cases:
  - read at BASE_ADDR+0x20 -> 0, Device_Hit=0;
  - write STATUS -> no change;
  - read and write DIGITS in the same cycle -> old value returned;
  - byte offset BASE+0x1 is treated as DIGITS.
- Async reset mid-write: assert reset between clk edges during a CTRL write -> outputs go inactive without a clk edge; the write is lost.
